// File: rtl/ttt_uart_pkg.sv
// Shared definitions for the UART transmit arbiter: requester IDs, FSM states
// and the round-robin pointer advance helper.
package ttt_uart_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int REQ_IDX_W   = 2;

  localparam logic [REQ_IDX_W-1:0] REQ_GAME   = 2'd0;
  localparam logic [REQ_IDX_W-1:0] REQ_ECHO   = 2'd1;
  localparam logic [REQ_IDX_W-1:0] REQ_STATUS = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic logic [REQ_IDX_W-1:0] next_idx(input logic [REQ_IDX_W-1:0] idx,
                                                    input int unsigned n);
    logic [REQ_IDX_W-1:0] res;
    if (32'(idx) >= n - 32'd1) begin
      res = 2'd0;
    end else begin
      res = idx + 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// ptr_i with wrap-around; returns one-hot, index and an any-request flag.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0] k_s;

  // Walk the candidates in rotation order, keeping the first hit.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    k_s     = '0;
    for (int i = 0; i < N; i++) begin
      k_s = {1'b0, ptr_i} + (IW+1)'(i);
      if (k_s >= (IW+1)'(N)) begin
        k_s = k_s - (IW+1)'(N);
      end else begin
        k_s = k_s;
      end
      if (!any_o && req_i[k_s[IW-1:0]]) begin
        any_o                 = 1'b1;
        idx_o                 = k_s[IW-1:0];
        grant_o[k_s[IW-1:0]] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-based round-robin arbiter sharing one UART TX byte interface between
// several requesters, with byte-count and idle watchdogs forcing release.
module uart_tx_arbiter
  import ttt_uart_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int MAX_PKT      = 32,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic                   abort_o,
  output logic [REQ_IDX_W-1:0]   abort_id_o
);

  localparam int IW  = REQ_IDX_W;
  localparam int BCW = $clog2(MAX_PKT + 1);
  localparam int ICW = $clog2(IDLE_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      abort_id_q, abort_id_d;
  logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [ICW-1:0]     idle_cnt_q, idle_cnt_d;
  logic               busy_q, busy_d;
  logic               abort_q, abort_d;

  logic [NUM_REQ-1:0] pick_oh_s;
  logic [IW-1:0]      pick_idx_s;
  logic               pick_any_s;
  logic               g_valid_s, g_last_s, xfer_s;
  logic [7:0]         g_data_s;
  logic               rel_s, force_s;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_oh_s),
    .idx_o   (pick_idx_s),
    .any_o   (pick_any_s)
  );

  // Owner's byte stream; grant_q is zero when idle so nothing passes through.
  always_comb begin
    g_valid_s = |(req_valid_i & grant_q);
    g_last_s  = |(req_last_i & grant_q);
    g_data_s  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      g_data_s = g_data_s | (req_data_i[8*i +: 8] & {8{grant_q[i]}});
    end
    xfer_s = g_valid_s & tx_ready_i;
  end

  assign tx_valid_o  = g_valid_s;
  assign tx_data_o   = g_data_s;
  assign req_ready_o = grant_q & {NUM_REQ{tx_ready_i}};
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign abort_o     = abort_q;
  assign abort_id_o  = abort_id_q;

  // Next-state logic: grant in IDLE, watch the packet and watchdogs in SEND.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    abort_id_d = abort_id_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    busy_d     = busy_q;
    abort_d    = 1'b0;
    rel_s      = 1'b0;
    force_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_d    = ST_SEND;
          grant_d    = pick_oh_s;
          gidx_d     = pick_idx_s;
          busy_d     = 1'b1;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      ST_SEND: begin
        if (xfer_s) begin
          idle_cnt_d = '0;
          byte_cnt_d = (byte_cnt_q == BCW'(MAX_PKT)) ? byte_cnt_q : byte_cnt_q + BCW'(1);
          if (g_last_s) begin
            rel_s = 1'b1;
          end else if (byte_cnt_q >= BCW'(MAX_PKT - 1)) begin
            rel_s   = 1'b1;
            force_s = 1'b1;
          end else begin
            rel_s = 1'b0;
          end
        end else if (!g_valid_s) begin
          // Only a genuinely absent byte counts as idle; backpressure holds.
          if (idle_cnt_q >= ICW'(IDLE_TIMEOUT - 1)) begin
            rel_s   = 1'b1;
            force_s = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + ICW'(1);
          end
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
        if (rel_s) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          busy_d     = 1'b0;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
          ptr_d      = next_idx(gidx_q, NUM_REQ);
          abort_d    = force_s;
          abort_id_d = force_s ? gidx_q : abort_id_q;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      abort_id_q <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      abort_id_q <= abort_id_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table for single-requester
// transfers plus hand-written rotation, watchdog and reset sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid, req_last, req_ready, grant;
  logic [23:0] req_data;
  logic        tx_valid, tx_ready, busy, abort;
  logic [7:0]  tx_data;
  logic [1:0]  abort_id;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .grant_o     (grant),
    .busy_o      (busy),
    .abort_o     (abort),
    .abort_id_o  (abort_id)
  );

  typedef struct {
    logic [2:0]  v;
    logic [23:0] d;
    logic [2:0]  l;
    logic        rdy;
    logic [2:0]  e_gnt;
    logic        e_tv;
    logic [7:0]  e_td;
    logic [2:0]  e_rr;
    logic        e_busy;
    logic        e_abort;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic [2:0] v, input logic [23:0] d, input logic [2:0] l,
                              input logic rdy, input logic [2:0] g, input logic tv,
                              input logic [7:0] td, input logic [2:0] rr, input logic b,
                              input logic a);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.rdy = rdy;
    r.e_gnt = g; r.e_tv = tv; r.e_td = td; r.e_rr = rr; r.e_busy = b; r.e_abort = a;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, then wait to mid-cycle.
  task automatic apply(input logic rst, input logic [2:0] v, input logic [23:0] d,
                       input logic [2:0] l, input logic rdy);
    @(posedge clk);
    #1;
    reset = rst; req_valid = v; req_data = d; req_last = l; tx_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(1'b1, 3'b000, 24'h0, 3'b000, 1'b1);
    apply(1'b1, 3'b000, 24'h0, 3'b000, 1'b1);
  endtask

  initial begin
    int sent [3];
    int xcnt, pkt, exp_t, n0, s0, s1;
    logic [7:0] exp_d;
    logic [2:0] v, l;
    logic [23:0] d;
    logic early;

    reset = 1'b1; req_valid = 3'b000; req_data = 24'h0; req_last = 3'b000; tx_ready = 1'b1;

    tbl[0]  = mk(3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
    tbl[1]  = mk(3'b010, 24'h004100, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
    tbl[2]  = mk(3'b010, 24'h004100, 3'b000, 1'b1, 3'b010, 1'b1, 8'h41, 3'b010, 1'b1, 1'b0);
    tbl[3]  = mk(3'b010, 24'h004200, 3'b000, 1'b1, 3'b010, 1'b1, 8'h42, 3'b010, 1'b1, 1'b0);
    tbl[4]  = mk(3'b010, 24'h004300, 3'b010, 1'b1, 3'b010, 1'b1, 8'h43, 3'b010, 1'b1, 1'b0);
    tbl[5]  = mk(3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
    tbl[6]  = mk(3'b010, 24'h005000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
    tbl[7]  = mk(3'b010, 24'h005000, 3'b000, 1'b0, 3'b010, 1'b1, 8'h50, 3'b000, 1'b1, 1'b0);
    tbl[8]  = mk(3'b010, 24'h005000, 3'b000, 1'b1, 3'b010, 1'b1, 8'h50, 3'b010, 1'b1, 1'b0);
    tbl[9]  = mk(3'b010, 24'h005100, 3'b000, 1'b0, 3'b010, 1'b1, 8'h51, 3'b000, 1'b1, 1'b0);
    tbl[10] = mk(3'b010, 24'h005100, 3'b000, 1'b1, 3'b010, 1'b1, 8'h51, 3'b010, 1'b1, 1'b0);
    tbl[11] = mk(3'b010, 24'h005200, 3'b000, 1'b0, 3'b010, 1'b1, 8'h52, 3'b000, 1'b1, 1'b0);
    tbl[12] = mk(3'b010, 24'h005200, 3'b000, 1'b1, 3'b010, 1'b1, 8'h52, 3'b010, 1'b1, 1'b0);
    tbl[13] = mk(3'b010, 24'h005300, 3'b010, 1'b0, 3'b010, 1'b1, 8'h53, 3'b000, 1'b1, 1'b0);
    tbl[14] = mk(3'b010, 24'h005300, 3'b010, 1'b1, 3'b010, 1'b1, 8'h53, 3'b010, 1'b1, 1'b0);
    tbl[15] = mk(3'b000, 24'h000000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0);

    // Vector table: reset state, 3-byte packet, then 4-byte packet under toggling tx_ready.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rdy);
      chk($sformatf("vec%0d {grant,tv,td,rr,busy,abort}", i),
          {grant, tx_valid, tx_data, req_ready, busy, abort},
          {tbl[i].e_gnt, tbl[i].e_tv, tbl[i].e_td, tbl[i].e_rr, tbl[i].e_busy, tbl[i].e_abort});
    end

    // Rotation: three requesters, two 2-byte packets each, all valid from reset.
    do_reset();
    for (int i = 0; i < 3; i++) sent[i] = 0;
    xcnt = 0;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 3; i++) begin
        v[i] = (sent[i] < 4);
        d[8*i +: 8] = {i[1:0], 2'b00, sent[i][3:0]};
        l[i] = sent[i][0];
      end
      apply(1'b0, v, d, l, 1'b1);
      if (tx_valid && tx_ready) begin
        pkt   = xcnt / 2;
        exp_t = 1 + pkt * 3 + (xcnt % 2);
        exp_d = {2'(pkt % 3), 2'b00, 4'((pkt / 3) * 2 + (xcnt % 2))};
        if (xcnt < 12) begin
          chk($sformatf("rot_time%0d", xcnt), t, exp_t);
          chk($sformatf("rot_data%0d", xcnt), tx_data, exp_d);
        end
        xcnt++;
        for (int i = 0; i < 3; i++) if (req_ready[i]) sent[i]++;
      end
    end
    chk("rot_count", xcnt, 12);

    // Idle watchdog: req 2 sends one byte and goes quiet while req 0 waits.
    do_reset();
    apply(1'b0, 3'b100, 24'h770000, 3'b000, 1'b1);
    apply(1'b0, 3'b101, 24'h770005, 3'b001, 1'b1);
    chk("to_first_byte", {grant, tx_valid, tx_data}, {3'b100, 1'b1, 8'h77});
    early = 1'b0;
    for (int t = 2; t <= 1025; t++) begin
      apply(1'b0, 3'b001, 24'h000005, 3'b001, 1'b1);
      if (abort) early = 1'b1;
      if (t == 1025) chk("to_hold_grant", grant, 3'b100);
    end
    chk("to_no_early_abort", early, 1'b0);
    apply(1'b0, 3'b001, 24'h000005, 3'b001, 1'b1);
    chk("to_abort {abort,id,grant,busy}", {abort, abort_id, grant, busy}, {1'b1, 2'd2, 3'b000, 1'b0});
    apply(1'b0, 3'b001, 24'h000005, 3'b001, 1'b1);
    chk("to_next {abort,grant,td}", {abort, grant, tx_data}, {1'b0, 3'b001, 8'h05});

    // Byte watchdog: req 0 streams without last while req 1 is pending.
    do_reset();
    s0 = 0; s1 = 0; n0 = 0;
    for (int t = 0; t < 37; t++) begin
      v = {1'b0, (s1 == 0), (s0 < 37 && t < 34)};
      d = {8'h00, 8'h99, s0[7:0]};
      apply(1'b0, v, d, 3'b010, 1'b1);
      if (t == 32) chk("mp_no_abort_yet", abort, 1'b0);
      if (t == 33) chk("mp_abort {abort,id,grant,busy,tv}", {abort, abort_id, grant, busy, tx_valid},
                       {1'b1, 2'd0, 3'b000, 1'b0, 1'b0});
      if (t == 34) chk("mp_next {grant,tv,td}", {grant, tx_valid, tx_data}, {3'b010, 1'b1, 8'h99});
      if (tx_valid && tx_ready) begin
        if (grant[0]) begin s0++; n0++; end
        if (grant[1]) s1++;
      end
    end
    chk("mp_bytes_req0", n0, 32);

    // Reset mid-packet after moving the pointer away from 0.
    do_reset();
    apply(1'b0, 3'b010, 24'h001100, 3'b010, 1'b1);
    apply(1'b0, 3'b010, 24'h001100, 3'b010, 1'b1);
    chk("rs_req1 {grant,td}", {grant, tx_data}, {3'b010, 8'h11});
    apply(1'b0, 3'b001, 24'h0000A0, 3'b000, 1'b1);
    apply(1'b0, 3'b001, 24'h0000A0, 3'b000, 1'b1);
    chk("rs_byte0 {grant,td}", {grant, tx_data}, {3'b001, 8'hA0});
    apply(1'b0, 3'b001, 24'h0000A1, 3'b000, 1'b1);
    apply(1'b1, 3'b001, 24'h0000A2, 3'b000, 1'b1);
    apply(1'b0, 3'b101, 24'h2200A0, 3'b100, 1'b1);
    chk("rs_cleared {grant,tv,busy,abort}", {grant, tx_valid, busy, abort}, {3'b000, 1'b0, 1'b0, 1'b0});
    apply(1'b0, 3'b101, 24'h2200A0, 3'b100, 1'b1);
    chk("rs_first_grant", grant, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
